glb_v2: RTL and testbench

- Parametrised second-generation global buffer: a word-organised SRAM model.
- Provides a valid/ready request channel with per-byte write strobes.
- Read responses leave through a 2-entry buffered valid/ready channel, so PE-side consumers may stall.
- A built-in clear engine zeroes the array on command; async reset only resets control state. Sits between the DMA/host bus and PE-array loaders.

---
 rtl/glb_pkg.sv | 18 +
 rtl/glb_rsp_fifo.sv | 66 ++++++
 rtl/glb_v2.sv | 169 ++++++++++++++++
 tb/tb_glb_v2.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared types, default sizes and helpers for the glb_v2 global buffer.
package glb_pkg;

    localparam int GLB_DATA_W = 32;
    localparam int GLB_DEPTH  = 16384;
    localparam int GLB_ADDR_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } glb_state_e;

    // Even parity: the stored bit gives the byte plus parity an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/glb_rsp_fifo.sv
// Two-entry response FIFO carrying {perr, rdata}; the head is held while stalled.
module glb_rsp_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] entry_q [2];
    logic [W-1:0] entry_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && (count_q != 2'd2);

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            entry_d[wr_ptr_q] = push_data;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign valid = (count_q != 2'd0);
    assign head  = entry_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/glb_v2.sv
// Word-organised global buffer with strobed writes, buffered read responses and a clear engine.
// Optional per-byte parity storage is enabled by defining GLB_PARITY_EN.
module glb_v2
    import glb_pkg::*;
#(
    parameter  int DATA_W = GLB_DATA_W,
    parameter  int DEPTH  = GLB_DEPTH,
    parameter  int ADDR_W = GLB_ADDR_W,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              misalign,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              par_inj
);

    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = $clog2(DEPTH);

    glb_state_e        state_q, state_d;
    logic [MEM_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_done_q, clr_done_d;
    logic              misalign_q, misalign_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wbe;

    logic [IDX_W-1:0]  word_idx;
    logic [MEM_AW-1:0] mem_idx;
    logic              in_range, accept, is_write;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;
    logic [1:0]        fifo_count;
    logic [DATA_W:0]   fifo_head;

    assign word_idx = req_addr[ADDR_W-1:OFF_W];
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign in_range = (32'(word_idx) < 32'(DEPTH));
    assign is_write = |req_strb;
    // A clear request wins over a request presented in the same cycle.
    assign accept   = req_valid && req_ready && !clr_start;
    assign rd_data  = in_range ? mem[mem_idx] : '0;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        misalign_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = mem_idx;
        mem_wdata  = req_wdata;
        mem_wbe    = req_strb;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end
                if (accept) begin
                    misalign_d = |req_addr[OFF_W-1:0];
                    mem_we     = is_write && in_range;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                if (clr_cnt_q == MEM_AW'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + MEM_AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            clr_done_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_done_q <= clr_done_d;
            misalign_q <= misalign_d;
        end
    end

    // NOTE: the array has no reset; only the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

`ifdef GLB_PARITY_EN
    logic [STRB_W-1:0] par_mem [DEPTH];
    logic [STRB_W-1:0] wr_par, rd_calc;

    always_comb begin
        wr_par  = '0;
        rd_calc = '0;
        for (int i = 0; i < STRB_W; i++) begin
            wr_par[i]  = byte_parity(mem_wdata[8*i +: 8]) ^ (par_inj && state_q == ST_IDLE);
            rd_calc[i] = byte_parity(rd_data[8*i +: 8]);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (mem_wbe[i]) begin
                    par_mem[mem_waddr][i] <= wr_par[i];
                end
            end
        end
    end

    assign rd_perr = in_range && (par_mem[mem_idx] != rd_calc);
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign rd_perr        = 1'b0;
`endif

    glb_rsp_fifo #(.W(DATA_W + 1)) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && !is_write),
        .push_data ({rd_perr, rd_data}),
        .pop       (rsp_valid && rsp_ready),
        .valid     (rsp_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign req_ready = (state_q == ST_IDLE) && (fifo_count != 2'd2);
    assign rsp_rdata = fifo_head[DATA_W-1:0];
    assign rsp_perr  = fifo_head[DATA_W];
    assign misalign  = misalign_q;
    assign clr_busy  = (state_q == ST_CLEAR);
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_glb_v2.sv
// Directed self-checking bench for glb_v2 (default parameters; GLB_PARITY_EN optional).
module tb_glb_v2;

    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_strb;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_perr, misalign;
    logic        clr_start, clr_busy, clr_done, par_inj;

    int compared   = 0;
    int mismatched = 0;

    glb_v2 dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_strb  (req_strb),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .misalign  (misalign),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .par_inj   (par_inj)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, simulation stalled");
        $fatal(1, "watchdog");
    end

    // Presents one request and returns 1 time unit after the accepting edge.
    task automatic send(input logic [3:0] strb, input logic [15:0] addr,
                        input logic [31:0] data, input logic inj);
        int n = 0;
        req_valid = 1'b1;
        req_strb  = strb;
        req_addr  = addr;
        req_wdata = data;
        par_inj   = inj;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: req_ready stayed low for %0d cycles at addr %h", n, addr);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_strb  = '0;
        par_inj   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({rsp_valid, misalign, clr_busy, clr_done} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_outputs: {rsp_valid,misalign,clr_busy,clr_done}=%b expected 0000",
                     {rsp_valid, misalign, clr_busy, clr_done});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_byte_strobe();
        send(4'b1111, 16'h0010, 32'hDEADBEEF, 1'b0);
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL write_no_rsp: rsp_valid=%b expected 0", rsp_valid);
        end
        send(4'b0101, 16'h0010, 32'h11223344, 1'b0);
        send(4'b0000, 16'h0010, 32'h0, 1'b0);
        compared++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDE22BE44 || rsp_perr !== 1'b0) begin
            mismatched++;
            $display("FAIL strb_read: valid=%b data=%h perr=%b expected 1 DE22BE44 0",
                     rsp_valid, rsp_rdata, rsp_perr);
        end
        @(posedge clk); #1;
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL strb_drain: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        send(4'b1111, 16'h0004, 32'h11110001, 1'b0);
        send(4'b1111, 16'h0008, 32'h22220002, 1'b0);
        send(4'b1111, 16'h000C, 32'h33330003, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_strb  = 4'b0000;
        req_addr  = 16'h0004;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_first: req_ready=%b rsp_valid=%b expected 1 1", req_ready, rsp_valid);
        end
        req_addr = 16'h0008;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b0 || rsp_rdata !== 32'h11110001) begin
            mismatched++;
            $display("FAIL bp_full: req_ready=%b data=%h expected 0 11110001", req_ready, rsp_rdata);
        end
        req_addr = 16'h000C;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b0 || rsp_rdata !== 32'h11110001) begin
            mismatched++;
            $display("FAIL bp_hold: req_ready=%b data=%h expected 0 11110001", req_ready, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b1 || rsp_rdata !== 32'h22220002) begin
            mismatched++;
            $display("FAIL bp_second: req_ready=%b data=%h expected 1 22220002", req_ready, rsp_rdata);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        compared++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33330003) begin
            mismatched++;
            $display("FAIL bp_third: valid=%b data=%h expected 1 33330003", rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        compared++;
        if (rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_empty: rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_misalign();
        send(4'b1111, 16'h0010, 32'hCAFEF00D, 1'b0);
        compared++;
        if (misalign !== 1'b0) begin
            mismatched++;
            $display("FAIL misalign_aligned: got %b expected 0", misalign);
        end
        send(4'b0000, 16'h0013, 32'h0, 1'b0);
        compared++;
        if (misalign !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
            mismatched++;
            $display("FAIL misalign_read: misalign=%b data=%h expected 1 CAFEF00D", misalign, rsp_rdata);
        end
        @(posedge clk); #1;
        compared++;
        if (misalign !== 1'b0) begin
            mismatched++;
            $display("FAIL misalign_pulse: got %b expected 0", misalign);
        end
        send(4'b1111, 16'h0015, 32'h0BADCAFE, 1'b0);
        compared++;
        if (misalign !== 1'b1) begin
            mismatched++;
            $display("FAIL misalign_write: got %b expected 1", misalign);
        end
        send(4'b0000, 16'h0014, 32'h0, 1'b0);
        compared++;
        if (rsp_rdata !== 32'h0BADCAFE || misalign !== 1'b0) begin
            mismatched++;
            $display("FAIL misalign_wordwrite: data=%h misalign=%b expected 0BADCAFE 0", rsp_rdata, misalign);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int n = 0;
        int rdy_seen = 0;
        int done_seen = 0;
        send(4'b1111, 16'h0014, 32'hA5A5A5A5, 1'b0);
        clr_start = 1'b1;
        req_valid = 1'b1;
        req_strb  = 4'b0000;
        req_addr  = 16'h0014;
        @(posedge clk); #1;
        clr_start = 1'b0;
        compared++;
        if (clr_busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_start: busy=%b rsp_valid=%b req_ready=%b expected 1 0 0",
                     clr_busy, rsp_valid, req_ready);
        end
        while (clr_busy === 1'b1 && n < DEPTH + 20) begin
            n++;
            if (req_ready !== 1'b0) rdy_seen++;
            if (clr_done !== 1'b0) done_seen++;
            clr_start = (n == 50);
            @(posedge clk); #1;
        end
        clr_start = 1'b0;
        compared++;
        if (n != DEPTH) begin
            mismatched++;
            $display("FAIL clr_busy_len: busy for %0d cycles expected %0d", n, DEPTH);
        end
        compared++;
        if (rdy_seen != 0 || done_seen != 0) begin
            mismatched++;
            $display("FAIL clr_during: req_ready high %0d and clr_done high %0d cycles expected 0 0",
                     rdy_seen, done_seen);
        end
        compared++;
        if (clr_done !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL clr_done: done=%b req_ready=%b rsp_valid=%b expected 1 1 0",
                     clr_done, req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        compared++;
        if (clr_done !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL clr_readback: done=%b valid=%b data=%h expected 0 1 00000000",
                     clr_done, rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_clear();
        int bad = 0;
        send(4'b1111, 16'h04B0, 32'h12345678, 1'b0);
        send(4'b1111, 16'h0010, 32'h55AA55AA, 1'b0);
        rsp_ready = 1'b0;
        send(4'b0000, 16'h0010, 32'h0, 1'b0);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
        end
        compared++;
        if (clr_busy !== 1'b1 || rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL rstclr_pre: busy=%b rsp_valid=%b expected 1 1", clr_busy, rsp_valid);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (clr_busy !== 1'b0 || rsp_valid !== 1'b0 || clr_done !== 1'b0) begin
            mismatched++;
            $display("FAIL rstclr_async: busy=%b rsp_valid=%b done=%b expected 0 0 0",
                     clr_busy, rsp_valid, clr_done);
        end
        #2 rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL rstclr_nodone: clr_done/clr_busy high in %0d cycles expected 0", bad);
        end
        send(4'b0000, 16'h0010, 32'h0, 1'b0);
        compared++;
        if (rsp_rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL rstclr_cleared: data=%h expected 00000000", rsp_rdata);
        end
        send(4'b0000, 16'h04B0, 32'h0, 1'b0);
        compared++;
        if (rsp_rdata !== 32'h12345678) begin
            mismatched++;
            $display("FAIL rstclr_kept: data=%h expected 12345678", rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_parity();
        logic exp_perr;
`ifdef GLB_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        send(4'b1111, 16'h0020, 32'h0F0F0F0F, 1'b1);
        send(4'b0000, 16'h0020, 32'h0, 1'b0);
        compared++;
        if (rsp_perr !== exp_perr || rsp_rdata !== 32'h0F0F0F0F) begin
            mismatched++;
            $display("FAIL parity_inj: perr=%b data=%h expected %b 0F0F0F0F", rsp_perr, rsp_rdata, exp_perr);
        end
        send(4'b1111, 16'h0020, 32'h0F0F0F0F, 1'b0);
        send(4'b0000, 16'h0020, 32'h0, 1'b0);
        compared++;
        if (rsp_perr !== 1'b0) begin
            mismatched++;
            $display("FAIL parity_clean: perr=%b expected 0", rsp_perr);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_strb  = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        clr_start = 1'b0;
        par_inj   = 1'b0;
        test_reset();
        test_byte_strobe();
        test_back_to_back();
        test_misalign();
        test_clear();
        test_rst_mid_clear();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
